// File: rtl/mc_array_ctrl_pkg.sv
// Shared types and defaults for the memristor array sequencer.
// Holds the FSM state encoding, the array geometry and pulse-length
// defaults, and the per-column bit-line/select-line command helper.
package mc_array_ctrl_pkg;

  localparam int N_ROWS_DEF    = 64;
  localparam int N_COLS_DEF    = 64;
  localparam int PULSE_CYC_DEF = 2;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    WL_SETUP,
    WR_P0,
    WR_P1,
    RD_ARM,
    RD_EVAL,
    WL_REL,
    RSP
  } state_t;

  // {CBL, CSL} for one column during a program phase.
  // Phase 0 stores data into m0, phase 1 stores ~data into m1.
  function automatic logic [1:0] phase_cmd(input logic phase, input logic data);
    return phase ? {~data, ~data} : {~data, data};
  endfunction

endpackage

// File: rtl/mc_array_ctrl_if.sv
// Request/response bus of the array sequencer.
// master = client issuing row requests, slave = the sequencer.
interface mc_array_ctrl_if
  import mc_array_ctrl_pkg::*;
#(
  parameter int N_ROWS = N_ROWS_DEF,
  parameter int N_COLS = N_COLS_DEF
);
  localparam int ROW_W = $clog2(N_ROWS);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ROW_W-1:0]  req_row;
  logic [N_COLS-1:0] req_data;
  logic [N_COLS-1:0] req_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N_COLS-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_row, req_data, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_row, req_data, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mc_row_decoder.sv
// Word-line decoder: even rows on CWLO, odd rows on CWLE.
// Takes the latched row index and the next-cycle word-line enable and
// registers a one-hot (or all-zero) word-line vector, so the word lines
// line up with the other registered array controls.
module mc_row_decoder #(
  parameter int N_ROWS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(N_ROWS)-1:0] row,
  input  logic                     en,
  output logic [N_ROWS/2-1:0]      cwle,
  output logic [N_ROWS/2-1:0]      cwlo
);
  localparam int ROW_W = $clog2(N_ROWS);

  // One word line at most; all lines drop asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cwle <= '0;
      cwlo <= '0;
    end else begin
      cwle <= '0;
      cwlo <= '0;
      if (en) begin
        if (row[0]) cwle[row[ROW_W-1:1]] <= 1'b1;
        else        cwlo[row[ROW_W-1:1]] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_array_ctrl.sv
// Sequencer for a 64x64 two-memristor-per-cell compute array.
// Turns row write/read requests into timed WL/BL/SL/DIN waveforms and
// captures DOUT. Array controls are registered from the current state, so
// they appear one clock after the state that produces them.
// Optional feature macro: MC_ARRAY_CTRL_WRITE_VERIFY_EN (write followed by
// a read-back of the same row and a mismatch flag on rsp_err).
module mc_array_ctrl
  import mc_array_ctrl_pkg::*;
#(
  parameter int N_ROWS    = N_ROWS_DEF,
  parameter int N_COLS    = N_COLS_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mc_array_ctrl_if.slave      bus,
  output logic [N_ROWS/2-1:0] CWLE,
  output logic [N_ROWS/2-1:0] CWLO,
  output logic [N_COLS-1:0]   CBLEN,
  output logic [N_COLS-1:0]   CBL,
  output logic [N_COLS-1:0]   CSL,
  output logic [N_COLS-1:0]   DIN,
  output logic [N_COLS-1:0]   DINb,
  input  logic [N_COLS-1:0]   DOUT
);
  localparam int               ROW_W    = $clog2(N_ROWS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYC - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              rdy_q;
  logic              rsp_vld_q;
  logic [N_COLS-1:0] rsp_data_q;
  logic [ROW_W-1:0]  row_q;
  logic [N_COLS-1:0] data_q;
  logic [N_COLS-1:0] mask_q;

  logic              accept;
  logic              phase_last;
  logic              wl_en_d;
  logic [N_COLS-1:0] cblen_d, cbl_d, csl_d, din_d, dinb_d;

`ifdef MC_ARRAY_CTRL_WRITE_VERIFY_EN
  logic vfy_q;
  logic rsp_err_q;
`endif

  assign accept     = bus.req_valid && rdy_q;
  assign phase_last = (cnt_q == CNT_LAST);

  // Request operands; datapath only, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_q  <= bus.req_row;
      data_q <= bus.req_data;
      mask_q <= bus.req_mask;
    end
  end

  // Sequencing FSM with a saturating per-phase cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
`ifdef MC_ARRAY_CTRL_WRITE_VERIFY_EN
      vfy_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            we_q    <= bus.req_we;
            state_q <= WL_SETUP;
`ifdef MC_ARRAY_CTRL_WRITE_VERIFY_EN
            vfy_q   <= 1'b0;
`endif
          end
        end
        WL_SETUP: begin
          cnt_q   <= '0;
          state_q <= we_q ? WR_P0 : RD_ARM;
        end
        WR_P0, WR_P1, RD_ARM, RD_EVAL: begin
          if (phase_last) begin
            cnt_q <= '0;
            case (state_q)
              WR_P0:   state_q <= WR_P1;
              WR_P1:   state_q <= WL_REL;
              RD_ARM:  state_q <= RD_EVAL;
              default: state_q <= RSP;
            endcase
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WL_REL: begin
`ifdef MC_ARRAY_CTRL_WRITE_VERIFY_EN
          // Keep the word line up and re-enter setup as a read of the same row.
          we_q    <= 1'b0;
          vfy_q   <= 1'b1;
          state_q <= WL_SETUP;
`else
          state_q <= IDLE;
`endif
        end
        RSP: begin
          if (rsp_vld_q && bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array command values implied by the current state.
  always_comb begin
    wl_en_d = 1'b0;
    cblen_d = '0;
    cbl_d   = '0;
    csl_d   = '0;
    din_d   = '0;
    dinb_d  = '0;
    case (state_q)
      WL_SETUP, WL_REL: wl_en_d = 1'b1;
      WR_P0, WR_P1: begin
        wl_en_d = 1'b1;
        cblen_d = mask_q;
        for (int c = 0; c < N_COLS; c++) begin
          {cbl_d[c], csl_d[c]} = phase_cmd(state_q == WR_P1, data_q[c]);
        end
      end
      RD_ARM: begin
        wl_en_d = 1'b1;
        csl_d   = '1;
        dinb_d  = '1;
      end
      RD_EVAL: begin
        wl_en_d = 1'b1;
        dinb_d  = '1;
      end
      default: ;
    endcase
  end

  // Registered array controls, handshake flags and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CBLEN      <= '0;
      CBL        <= '0;
      CSL        <= '0;
      DIN        <= '0;
      DINb       <= '0;
      rdy_q      <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      CBLEN     <= cblen_d;
      CBL       <= cbl_d;
      CSL       <= csl_d;
      DIN       <= din_d;
      DINb      <= dinb_d;
      rdy_q     <= (state_q == IDLE) && !accept;
      rsp_vld_q <= (state_q == RSP) && !(rsp_vld_q && bus.rsp_ready);
      // First RSP cycle: the evaluate waveform is still on the array pins.
      if (state_q == RSP && !rsp_vld_q) rsp_data_q <= DOUT;
    end
  end

`ifdef MC_ARRAY_CTRL_WRITE_VERIFY_EN
  // Read-back mismatch over the written columns; plain reads report 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == RSP && !rsp_vld_q) begin
      rsp_err_q <= vfy_q && (|((DOUT ^ data_q) & mask_q));
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_data  = rsp_data_q;

  mc_row_decoder #(.N_ROWS(N_ROWS)) u_row_decoder (
    .clk  (clk),
    .rst  (rst),
    .row  (row_q),
    .en   (wl_en_d),
    .cwle (CWLE),
    .cwlo (CWLO)
  );

endmodule

// File: tb/tb_mc_array_ctrl.sv
// Bench for mc_array_ctrl: table of row transactions against a behavioural
// two-memristor array model, plus reset, backpressure and mid-write reset
// sequences. Honours MC_ARRAY_CTRL_WRITE_VERIFY_EN (column 3 stuck at 0).
module tb_mc_array_ctrl;
  localparam int N_ROWS = 64;
  localparam int N_COLS = 64;
  localparam int ROW_W  = 6;
`ifdef MC_ARRAY_CTRL_WRITE_VERIFY_EN
  localparam bit          VFY   = 1'b1;
  localparam logic [63:0] STUCK = ~64'h8;
`else
  localparam bit          VFY   = 1'b0;
  localparam logic [63:0] STUCK = '1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_ROWS/2-1:0] CWLE, CWLO;
  logic [N_COLS-1:0]   CBLEN, CBL, CSL, DIN, DINb, DOUT;

  mc_array_ctrl_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) bus ();

  mc_array_ctrl #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .PULSE_CYC(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .CWLE(CWLE), .CWLO(CWLO), .CBLEN(CBLEN), .CBL(CBL), .CSL(CSL),
    .DIN(DIN), .DINb(DINb), .DOUT(DOUT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural array model ----------------
  logic [63:0] m0 [64];
  logic [63:0] m1 [64];
  logic [63:0] ref_mem [64];
  int rd_row;

  function automatic int active_row(input logic [31:0] e, input logic [31:0] o);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++) begin
      if (o[i]) r = 2 * i;
      if (e[i]) r = 2 * i + 1;
    end
    return r;
  endfunction

  // Program: CBL != CSL writes m0, CBL == CSL writes m1 (value = CSL).
  always @(posedge clk) begin
    if (active_row(CWLE, CWLO) >= 0) begin
      for (int c = 0; c < 64; c++) begin
        if (CBLEN[c]) begin
          if (CBL[c] != CSL[c]) m0[active_row(CWLE, CWLO)][c] <= CSL[c];
          else                  m1[active_row(CWLE, CWLO)][c] <= CSL[c];
        end
      end
    end
  end

  // Evaluate: programmed cells drive ~m1 while CSL=0 and DINb=1.
  always_comb begin
    DOUT   = '0;
    rd_row = active_row(CWLE, CWLO);
    if (rd_row >= 0 && CSL == '0 && DINb == '1 && CBLEN == '0) begin
      for (int c = 0; c < 64; c++) begin
        if (m0[rd_row][c] != m1[rd_row][c]) DOUT[c] = ~m1[rd_row][c];
      end
    end
    DOUT = DOUT & STUCK;
  end

  // At most one word line, every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) chk("wl_onehot", 64'($countones({CWLE, CWLO}) <= 1), 64'd1);
  end

  function automatic logic [31:0] exp_wl(input int row, input bit odd);
    logic [31:0] v;
    v = '0;
    if ((row % 2 == 1) == odd) v[row / 2] = 1'b1;
    return v;
  endfunction

  typedef struct {
    bit          we;
    int          row;
    logic [63:0] data;
    logic [63:0] mask;
    logic [63:0] exp;
  } vec_t;

  task automatic run_txn(input int id, input vec_t v, input int hold);
    int          k;
    int          rspk;
    int          lastk;
    int          wl_last;
    bit          has_rsp;
    logic [63:0] exp_d;
    logic        exp_e;
    logic [63:0] held;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("t%0d_ready_wait", id), 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_row   = ROW_W'(v.row);
    bus.req_data  = v.data;
    bus.req_mask  = v.mask;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (v.we) ref_mem[v.row] = (ref_mem[v.row] & ~v.mask) | (v.data & v.mask);
    has_rsp = !v.we || VFY;
    rspk    = v.we ? 12 : 6;
    if (v.we) begin
      exp_d = ref_mem[v.row] & STUCK;
      exp_e = |((exp_d ^ v.data) & v.mask);
    end else begin
      exp_d = v.exp & STUCK;
      exp_e = 1'b0;
    end
    lastk   = has_rsp ? rspk : 7;
    wl_last = v.we ? 6 : 5;
    for (int kk = 1; kk <= lastk; kk++) begin
      @(negedge clk);
      if (kk <= 6) begin
        chk($sformatf("t%0d_k%0d_cwle", id, kk), 64'(CWLE), 64'(kk <= wl_last ? exp_wl(v.row, 1'b1) : 32'd0));
        chk($sformatf("t%0d_k%0d_cwlo", id, kk), 64'(CWLO), 64'(kk <= wl_last ? exp_wl(v.row, 1'b0) : 32'd0));
      end
      if (v.we && kk >= 2 && kk <= 5) begin
        chk($sformatf("t%0d_k%0d_cblen", id, kk), CBLEN, v.mask);
        chk($sformatf("t%0d_k%0d_cbl", id, kk), CBL, ~v.data);
        chk($sformatf("t%0d_k%0d_csl", id, kk), CSL, (kk <= 3) ? v.data : ~v.data);
      end
      if (v.we && kk == 6) begin
        chk($sformatf("t%0d_rel_cblen", id), CBLEN | CSL | CBL, 64'd0);
        chk($sformatf("t%0d_busy_ready", id), 64'(bus.req_ready), 64'd0);
      end
`ifndef MC_ARRAY_CTRL_WRITE_VERIFY_EN
      if (v.we && kk == 7) chk($sformatf("t%0d_wr_ready", id), 64'(bus.req_ready), 64'd1);
`endif
      if (!v.we && (kk == 2 || kk == 3)) begin
        chk($sformatf("t%0d_k%0d_arm_csl", id, kk), CSL, '1);
        chk($sformatf("t%0d_k%0d_arm_dinb", id, kk), DINb, '1);
        chk($sformatf("t%0d_k%0d_arm_din", id, kk), DIN | CBLEN, 64'd0);
      end
      if (!v.we && (kk == 4 || kk == 5)) begin
        chk($sformatf("t%0d_k%0d_eval_csl", id, kk), CSL, 64'd0);
        chk($sformatf("t%0d_k%0d_eval_dinb", id, kk), DINb, '1);
      end
      if (has_rsp && kk == rspk - 1) chk($sformatf("t%0d_early_valid", id), 64'(bus.rsp_valid), 64'd0);
    end
    if (has_rsp) begin
      chk($sformatf("t%0d_rsp_valid", id), 64'(bus.rsp_valid), 64'd1);
      chk($sformatf("t%0d_rsp_data", id), bus.rsp_data, exp_d);
      chk($sformatf("t%0d_rsp_err", id), 64'(bus.rsp_err), 64'(exp_e));
      held = bus.rsp_data;
      for (int h = 0; h < hold; h++) begin
        // A competing write must not be accepted while the response waits.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_row   = ROW_W'(v.row);
        bus.req_data  = '0;
        bus.req_mask  = '1;
        @(negedge clk);
        chk($sformatf("t%0d_h%0d_valid", id, h), 64'(bus.rsp_valid), 64'd1);
        chk($sformatf("t%0d_h%0d_data", id, h), bus.rsp_data, held);
        chk($sformatf("t%0d_h%0d_ready", id, h), 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk($sformatf("t%0d_rsp_drop", id), 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {52'd0, |CWLE, |CWLO, |CBLEN, |CBL, |CSL, |DIN, |DINb,
               bus.rsp_valid, |bus.rsp_data, bus.rsp_err, bus.req_ready, 1'b0}, 64'd0);
  endtask

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_row   = '0;
    bus.req_data  = '0;
    bus.req_mask  = '0;
    bus.rsp_ready = 1'b0;
    for (int r = 0; r < 64; r++) ref_mem[r] = '0;

    tbl[0]  = '{1'b1, 5,  64'hA5A5_A5A5_A5A5_A5A5, '1,                    64'd0};
    tbl[1]  = '{1'b0, 5,  64'd0,                   64'd0,                 64'hA5A5_A5A5_A5A5_A5A5};
    tbl[2]  = '{1'b1, 0,  '1,                      '1,                    64'd0};
    tbl[3]  = '{1'b1, 0,  64'd0,                   64'h0000_0000_FFFF_FFFF, 64'd0};
    tbl[4]  = '{1'b0, 0,  64'd0,                   64'd0,                 64'hFFFF_FFFF_0000_0000};
    tbl[5]  = '{1'b1, 5,  64'd0,                   64'd0,                 64'd0};
    tbl[6]  = '{1'b0, 5,  64'd0,                   64'd0,                 64'hA5A5_A5A5_A5A5_A5A5};
    tbl[7]  = '{1'b1, 63, 64'h8000_0000_0000_0001, '1,                    64'd0};
    tbl[8]  = '{1'b0, 63, 64'd0,                   64'd0,                 64'h8000_0000_0000_0001};
    tbl[9]  = '{1'b1, 62, 64'h0123_4567_89AB_CDEF, '1,                    64'd0};
    tbl[10] = '{1'b0, 62, 64'd0,                   64'd0,                 64'h0123_4567_89AB_CDEF};
    tbl[11] = '{1'b1, 9,  64'h8,                   '1,                    64'd0};
    tbl[12] = '{1'b0, 9,  64'd0,                   64'd0,                 64'h8};

    // Reset at start and again while idle.
    repeat (3) @(negedge clk);
    chk_all_zero("rst_init_outputs");
    rst = 1'b0;
    #1 chk("rst_rel_ready_before_clk", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("rst_rel_ready", 64'(bus.req_ready), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_idle_outputs");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_rel_ready", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 13; i++) run_txn(i, tbl[i], 0);

    // Backpressure on a read, then confirm the blocked write never landed.
    run_txn(20, tbl[6], 10);
    run_txn(21, tbl[6], 0);

    // Reset in the middle of the second program phase.
    begin
      int k;
      k = 0;
      while (bus.req_ready !== 1'b1 && k < 40) begin
        @(negedge clk);
        k++;
      end
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_row   = ROW_W'(7);
      bus.req_data  = '1;
      bus.req_mask  = '1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("wrp1_cwle_before", 64'(CWLE), 64'(exp_wl(7, 1'b1)));
      chk("wrp1_cblen_before", CBLEN, '1);
      #2 rst = 1'b1;
      #1;
      chk("wrp1_rst_cwle", 64'(CWLE), 64'd0);
      chk("wrp1_rst_cblen", CBLEN, 64'd0);
      chk_all_zero("wrp1_rst_outputs");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("wrp1_rel_ready", 64'(bus.req_ready), 64'd1);
    end

    // Controller still works after the aborted write.
    run_txn(30, tbl[12], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_array_ctrl.md
Name: mc_array_ctrl

Overview:
- Sequencer that drives one 64x64 two-memristor-per-cell compute array.
- Converts row-wide write/read requests, via a valid/ready interface, into timed word-line, bit-line, select-line and data-line waveforms.
- Captures the array's DOUT word.
- Sits directly upstream of the array macro; owns every array control input.

Parameters:
- N_ROWS, 64, word lines in the array (even, CWLE/CWLO each N_ROWS/2 wide).
- N_COLS, 64, columns in the array.
- PULSE_CYC, 2, clock cycles per array phase (program, arm, evaluate); legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted when valid&&ready
- req_we  in  1  1=write row, 0=read row
- req_row  in  $clog2(N_ROWS)  target row
- req_data  in  N_COLS  write data (bit=1 stores logic 1)
- req_mask  in  N_COLS  per-column write enable (ignored on reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  N_COLS  read result
- rsp_err  out  1  write-verify mismatch (0 when feature absent)
- CWLE  out  N_ROWS/2  odd-row word lines
- CWLO  out  N_ROWS/2  even-row word lines
- CBLEN  out  N_COLS  bit-line enable (program)
- CBL  out  N_COLS  bit-line command bit
- CSL  out  N_COLS  select-line command/arm bit
- DIN  out  N_COLS  read operand, m0 path
- DINb  out  N_COLS  read operand, m1 path
- DOUT  in  N_COLS  array read data

Behaviour:
- Row decode: row r even -> CWLO[r/2]; r odd -> CWLE[r/2]. At most one word line is high at any time.
- Array outputs are all registered. Reset value of every output is 0, except req_ready, which is 0 in reset and 1 from the first clock after release.
- States: IDLE, WL_SETUP, WR_P0, WR_P1, RD_ARM, RD_EVAL, WL_REL, RSP.
- IDLE:
  - All array outputs 0; req_ready=1.
  - On accept, latch row/data/mask/we, req_ready->0, go to WL_SETUP.
- WL_SETUP (1 cycle): selected word line 1, CBLEN=0, CSL=0. Next state WR_P0 if we, else RD_ARM.
- WR_P0 (PULSE_CYC cycles): CBLEN=mask, CBL=~data, CSL=data. Result: m0=data per enabled column.
- WR_P1 (PULSE_CYC cycles): CBLEN=mask, CBL=~data, CSL=~data. Result: m1=~data. Then WL_REL.
- WL_REL (1 cycle): word line held, CBLEN/CBL/CSL=0. Then IDLE.
- Write latency: accept at T0, req_ready high again at T0+2*PULSE_CYC+3.
- RD_ARM (PULSE_CYC cycles): CBLEN=0, CSL=all ones, DIN=0, DINb=all ones.
- RD_EVAL (PULSE_CYC cycles):
  - CSL=0, DIN=0, DINb=all ones; array drives DOUT=~m1, i.e. the stored bit.
  - rsp_data <= DOUT on the last EVAL cycle.
- RSP:
  - All array outputs 0; rsp_valid=1.
  - rsp_data/rsp_err held stable until rsp_ready, then rsp_valid->0 and IDLE.
- Read latency: accept T0, rsp_valid first high at T0+2*PULSE_CYC+2.
- Cells with m0==m1 (never programmed) do not drive DOUT. The corresponding rsp_data bits are don't-care.
- A mask of 0 still runs the full write sequence, with no cell change.
- Phase counter saturates at PULSE_CYC-1; there is no wrap between phases.
- No new request is accepted while rsp_valid is high.
- Async reset mid-operation:
  - All array outputs drop to 0 immediately, with no clock edge required.
  - State returns to IDLE; the pending response is discarded.
  - A partially programmed row is left undefined.

Optional Feature:
- Macro: MC_ARRAY_CTRL_WRITE_VERIFY_EN.
- With the macro: after WL_REL of a write, the FSM re-enters WL_SETUP and runs the read sequence on the same row, then presents RSP.
  - rsp_data = readback.
  - rsp_err = |((readback ^ data) & mask).
- Without the macro: writes produce no response and rsp_err is tied to 0.

Decomposition:
- Package mc_array_ctrl_pkg holds:
  - the state enum;
  - N_ROWS/N_COLS defaults;
  - PULSE_CYC default;
  - a function phase_cmd(phase, data) returning {CBL,CSL}.
- Sub-module mc_row_decoder: registered row index plus enable in, CWLE/CWLO one-hot out.

Test Plan:
- Reset check: assert rst mid-idle -> all array outputs 0, rsp_valid=0, req_ready=0; req_ready=1 on first clock after release.
- Write row 5, data 0xA5A5_A5A5_A5A5_A5A5, mask all ones, PULSE_CYC=2:
  - only CWLE[2] high, from T1 through T6.
  - CBL/CSL = {~d,d} for 2 cycles, then {~d,~d} for 2 cycles.
  - req_ready high at T7.
- Read row 5 against a behavioural array model -> rsp_valid at T0+6, rsp_data=0xA5A5_A5A5_A5A5_A5A5; during arm CSL=all ones, DINb=all ones, DIN=0.
- Masked overwrite: row 0 all ones, then write zeros with mask 0x0000_0000_FFFF_FFFF -> only CWLO[0] asserted; read returns 0xFFFF_FFFF_0000_0000.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_data stable, req_ready=0, a new req_valid is not accepted.
- Reset during WR_P1 -> word line and CBLEN drop combinationally. With MC_ARRAY_CTRL_WRITE_VERIFY_EN and a stuck-at-0 model column 3, write 0x8 -> rsp_err=1.
